// File: rtl/keypad_matrix_scanner.sv
// Column-strobed key matrix scanner with a per-frame debounce FSM and a one-cycle key strobe.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_matrix_scanner #(
    parameter int CLOCK_HZ        = 10_000_000,
    parameter int SCAN_PERIOD_US  = 1000,
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 100
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [ROWS-1:0]                Rows_i,
    output logic [COLS-1:0]                Columns_o,
    output logic [$clog2(ROWS*COLS)-1:0]   KeyCode_o,
    output logic                           KeyValid_o,
    output logic                           KeyPressed_o
);

    localparam int SLOT = CLOCK_HZ / 1_000_000 * SCAN_PERIOD_US;
    localparam int SW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int KW   = $clog2(ROWS * COLS);
    localparam int DW   = $clog2(DEBOUNCE_FRAMES + 1);

    if (SLOT < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1 || ROWS * COLS < 2) begin : g_param_check
        $error("keypad_matrix_scanner: illegal parameter combination");
    end

    // Handshake: KeyValid_o is a single-cycle strobe with KeyCode_o valid in the same cycle; there
    // is no ready, so the consumer must take the code whenever the strobe is seen.

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;

    logic [ROWS-1:0] rows_meta, rows_sync;
    logic [SW-1:0]   slot_cnt;
    logic [CW-1:0]   col_idx;
    logic            sample, frame_end;
    logic            col_hit, cand_hit, frame_hit;
    logic [KW-1:0]   col_code, cand_code, frame_code;
    state_t          state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [KW-1:0]   key_q, key_d;
    logic            valid_d, pressed_d, rpt_fire;
    logic [KW-1:0]   code_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rows_meta <= '1;
            rows_sync <= '1;
        end else begin
            rows_meta <= Rows_i;
            rows_sync <= rows_meta;
        end
    end

    assign sample    = (slot_cnt == SW'(SLOT - 1));
    assign frame_end = sample && (col_idx == CW'(COLS - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            slot_cnt <= '0;
            col_idx  <= '0;
        end else if (sample) begin
            slot_cnt <= '0;
            col_idx  <= frame_end ? '0 : col_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    assign Columns_o = ~(COLS'(1) << col_idx);

    // Lowest pressed row in the column being sampled; scanning downwards leaves the lowest one.
    always_comb begin
        col_hit  = 1'b0;
        col_code = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!rows_sync[r]) begin
                col_hit  = 1'b1;
                col_code = KW'(int'(col_idx) * ROWS + r);
            end
        end
    end

    // The first hit of a frame sticks, so the final column only matters if nothing came before it.
    assign frame_hit  = cand_hit | col_hit;
    assign frame_code = cand_hit ? cand_code : col_code;

    always_ff @(posedge Clock) begin
        if (Reset || frame_end) begin
            cand_hit  <= 1'b0;
            cand_code <= '0;
        end else if (sample && !cand_hit && col_hit) begin
            cand_hit  <= 1'b1;
            cand_code <= col_code;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_hit) begin
                        key_d = frame_code;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d = HELD;
                            cnt_d   = '0;
                        end else begin
                            state_d = DEB_PRESS;
                            cnt_d   = DW'(1);
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!frame_hit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (frame_code != key_q) begin
                        key_d = frame_code;
                        cnt_d = DW'(1);
                    end else if (cnt_inc == DW'(DEBOUNCE_FRAMES)) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    if (frame_hit && frame_code == key_q) begin
                        cnt_d = '0;
                    end else if (DEBOUNCE_FRAMES == 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = DEB_RELEASE;
                        cnt_d   = DW'(1);
                    end
                end
                DEB_RELEASE: begin
                    if (frame_hit && frame_code == key_q) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_inc == DW'(DEBOUNCE_FRAMES)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    logic [RW-1:0] rpt_q;

    assign rpt_fire = frame_end && state_q == HELD && state_d == HELD && rpt_q == RW'(REPEAT_FRAMES - 1);

    always_ff @(posedge Clock) begin
        if (Reset || state_q != HELD) begin
            rpt_q <= '0;
        end else if (frame_end && state_d == HELD) begin
            rpt_q <= rpt_fire ? '0 : rpt_q + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Re-entering HELD from DEB_RELEASE is the same key still down, not a new press.
    always_comb begin
        valid_d = 1'b0;
        if (frame_end && state_d == HELD && (state_q == IDLE || state_q == DEB_PRESS)) begin
            valid_d = 1'b1;
        end
        if (rpt_fire) begin
            valid_d = 1'b1;
        end
        pressed_d = (state_d == HELD) || (state_d == DEB_RELEASE);
        code_d    = valid_d ? key_d : KeyCode_o;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            KeyCode_o    <= '0;
            KeyValid_o   <= 1'b0;
            KeyPressed_o <= 1'b0;
        end else begin
            KeyCode_o    <= code_d;
            KeyValid_o   <= valid_d;
            KeyPressed_o <= pressed_d;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: 10-cycle slots, 40-cycle frames, two-frame debounce.
// A behavioural key matrix pulls row lines low for pressed keys on the strobed column.
module tb_keypad_matrix_scanner;
    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Rows_i;
    logic [3:0]  Columns_o;
    logic [3:0]  KeyCode_o;
    logic        KeyValid_o;
    logic        KeyPressed_o;
    logic [15:0] keys = '0;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int base = 0;

    typedef struct {
        logic [15:0] keys;
        int          hold;
        int          pulses;
        int          code;
        int          pressed;
    } vec_t;

    vec_t vecs[10];

    always #5 Clock = ~Clock;

    keypad_matrix_scanner #(
        .CLOCK_HZ(10_000_000),
        .SCAN_PERIOD_US(1),
        .ROWS(ROWS),
        .COLS(COLS),
        .DEBOUNCE_FRAMES(2),
        .REPEAT_FRAMES(5)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Rows_i(Rows_i),
        .Columns_o(Columns_o),
        .KeyCode_o(KeyCode_o),
        .KeyValid_o(KeyValid_o),
        .KeyPressed_o(KeyPressed_o)
    );

    always_comb begin
        Rows_i = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (!Columns_o[c] && keys[c*ROWS+r]) Rows_i[r] = 1'b0;
            end
        end
    end

    always @(negedge Clock) begin
        if (!Reset && KeyValid_o) pulse_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ends on the first negedge after reset is released; that cycle is slot 0 of column 0.
    task automatic do_reset(input logic [15:0] k0);
        @(negedge Clock);
        Reset = 1'b1;
        keys  = '0;
        @(negedge Clock);
        Reset = 1'b0;
        keys  = k0;
        base  = pulse_cnt;
    endtask

    initial begin
        int first_v, rise, fall, vcyc, np;
        int pk[8];
        int pc[8];
        int exp_n;
        int exp_k[4];
        logic [3:0] exp_col;

        vecs[0] = '{16'h0040, 200, 1, 6,  1};
        vecs[1] = '{16'h0001, 200, 1, 0,  1};
        vecs[2] = '{16'h8000, 200, 1, 15, 1};
        vecs[3] = '{16'h0208, 200, 1, 3,  1};
        vecs[4] = '{16'h4020, 200, 1, 5,  1};
        vecs[5] = '{16'h1000, 200, 1, 12, 1};
        vecs[6] = '{16'h0000, 200, 0, 0,  0};
        vecs[7] = '{16'h0040, 40,  0, 0,  0};
        vecs[8] = '{16'h0040, 80,  1, 6,  1};
        vecs[9] = '{16'h0400, 80,  1, 10, 1};

        // Reset values and idle column rotation
        do_reset(16'h0000);
        check("rst_cols", int'(Columns_o), 4'b1110);
        check("rst_code", int'(KeyCode_o), 0);
        check("rst_valid", int'(KeyValid_o), 0);
        check("rst_pressed", int'(KeyPressed_o), 0);
        for (int k = 0; k < 400; k++) begin
            exp_col = ~(4'b0001 << ((k / 10) % 4));
            check("idle_cols", int'(Columns_o), int'(exp_col));
            @(negedge Clock);
        end
        check("idle_pulses", pulse_cnt - base, 0);
        check("idle_pressed", int'(KeyPressed_o), 0);

        // Table of press episodes, each from a fresh reset
        for (int i = 0; i < 10; i++) begin
            do_reset(vecs[i].keys);
            repeat (vecs[i].hold) @(negedge Clock);
            keys = '0;
            repeat (2) @(negedge Clock);
            check("vec_pulses", pulse_cnt - base, vecs[i].pulses);
            check("vec_code", int'(KeyCode_o), vecs[i].code);
            check("vec_pressed", int'(KeyPressed_o), vecs[i].pressed);
            repeat (120) @(negedge Clock);
            check("vec_rel_pulses", pulse_cnt - base, vecs[i].pulses);
            check("vec_rel_code", int'(KeyCode_o), vecs[i].code);
            check("vec_rel_pressed", int'(KeyPressed_o), 0);
        end

        // Exact press/release timing for key 6
        do_reset(16'h0040);
        first_v = -1; rise = -1; fall = -1; vcyc = 0;
        for (int k = 0; k < 320; k++) begin
            if (k == 200) keys = '0;
            if (KeyValid_o) begin
                vcyc++;
                if (first_v < 0) first_v = k;
            end
            if (KeyPressed_o && rise < 0) rise = k;
            if (!KeyPressed_o && rise >= 0 && fall < 0) fall = k;
            @(negedge Clock);
        end
        check("k6_valid_cycles", vcyc, 1);
        check("k6_first_valid", first_v, 80);
        check("k6_pressed_rise", rise, 80);
        check("k6_pressed_fall", fall, 280);
        check("k6_code", int'(KeyCode_o), 6);

        // Bouncing key: one frame on, one frame off
        do_reset(16'h0000);
        for (int f = 0; f < 10; f++) begin
            keys = (f % 2 == 0) ? 16'h0040 : 16'h0000;
            repeat (40) @(negedge Clock);
            check("bounce_pressed", int'(KeyPressed_o), 0);
        end
        check("bounce_pulses", pulse_cnt - base, 0);
        check("bounce_code", int'(KeyCode_o), 0);

        // Keys 9 and 3 together, then release key 3 only
        do_reset(16'h0208);
        np = 0; rise = -1; fall = -1;
        for (int k = 0; k < 420; k++) begin
            if (k == 200) keys = 16'h0200;
            if (KeyValid_o && np < 8) begin
                pk[np] = k;
                pc[np] = int'(KeyCode_o);
                np++;
            end
            if (KeyPressed_o && rise < 0) rise = k;
            if (!KeyPressed_o && rise >= 0 && fall < 0) fall = k;
            @(negedge Clock);
        end
        check("multi_pulses", np, 2);
        if (np >= 2) begin
            check("multi_first_cyc", pk[0], 80);
            check("multi_first_code", pc[0], 3);
            check("multi_second_cyc", pk[1], 360);
            check("multi_second_code", pc[1], 9);
        end
        check("multi_pressed_fall", fall, 280);
        check("multi_pressed_end", int'(KeyPressed_o), 1);

        // Reset pulse while HELD, mid-way through column 1
        do_reset(16'h0040);
        repeat (135) @(negedge Clock);
        check("hr_pressed_before", int'(KeyPressed_o), 1);
        check("hr_cols_before", int'(Columns_o), 4'b1101);
        Reset = 1'b1;
        @(negedge Clock);
        check("hr_cols", int'(Columns_o), 4'b1110);
        check("hr_code", int'(KeyCode_o), 0);
        check("hr_valid", int'(KeyValid_o), 0);
        check("hr_pressed", int'(KeyPressed_o), 0);
        Reset = 1'b0;
        keys  = '0;

        // Key 0 held for 20 frames: single strobe, or a strobe every 5 frames with auto-repeat
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_n = 4;
        exp_k = '{80, 280, 480, 680};
`else
        exp_n = 1;
        exp_k = '{80, 0, 0, 0};
`endif
        do_reset(16'h0001);
        np = 0;
        for (int k = 0; k < 880; k++) begin
            if (k == 800) keys = '0;
            if (KeyValid_o && np < 8) begin
                pk[np] = k;
                pc[np] = int'(KeyCode_o);
                np++;
            end
            @(negedge Clock);
        end
        check("long_pulses", np, exp_n);
        for (int i = 0; i < exp_n && i < np; i++) begin
            check("long_pulse_cyc", pk[i], exp_k[i]);
            check("long_pulse_code", pc[i], 0);
        end
        check("long_pressed_end", int'(KeyPressed_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
